// File: rtl/snf_txdat_if.sv
// Request and link-side signals of the SNF DAT transmitter.
// The master side is the flit source and the link receiver; the slave side is snf_txdat.
interface snf_txdat_if #(
  parameter int unsigned FLIT_WIDTH = 64
);
  logic                  txdat_req_valid;
  logic [FLIT_WIDTH-1:0] txdat_req_flit;
  logic                  txdat_req_ready;
  logic                  txdat_lcrdv;
  logic                  txdatflitpend;
  logic                  txdatflitv;
  logic [FLIT_WIDTH-1:0] txdatflit;

  modport master (
    output txdat_req_valid, txdat_req_flit, txdat_lcrdv,
    input  txdat_req_ready, txdatflitpend, txdatflitv, txdatflit
  );

  modport slave (
    input  txdat_req_valid, txdat_req_flit, txdat_lcrdv,
    output txdat_req_ready, txdatflitpend, txdatflitv, txdatflit
  );
endinterface

// File: rtl/snf_txdat.sv
// CHI-E DAT link-layer transmitter: buffers read-data flits, spends one link credit per flit,
// and on deactivation drains the FIFO before returning leftover credits as LCrdReturn flits.
module snf_txdat #(
  parameter int unsigned TXDAT_FIFO_DEPTH = 4,
  parameter int unsigned TXDAT_CRD_MAX    = 15,
  parameter int unsigned FLIT_WIDTH       = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_state,
  snf_txdat_if.slave  txdat,
  output logic        txdat_crd_ret_done,
  output logic        txdat_crd_ovf_err
);
  localparam int unsigned PtrW = $clog2(TXDAT_FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(TXDAT_CRD_MAX + 1);
  localparam logic [PtrW:0]   PtrOne = 1;
  localparam logic [CntW-1:0] CntOne = 1;
  localparam logic [CntW-1:0] CrdMax = CntW'(TXDAT_CRD_MAX);

  typedef enum logic [1:0] {StStop, StRun, StDrain, StReturn} state_e;

  state_e                state_q, state_d;
  logic [FLIT_WIDTH-1:0] mem_q [TXDAT_FIFO_DEPTH];
  logic [PtrW:0]         wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  flitv_q, pend_q, pend_d;
  logic [FLIT_WIDTH-1:0] flit_q, flit_d;
  logic                  empty, full, push, data_send, ret_send, any_send, crd_avail;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign crd_avail = (cnt_q != '0);

  assign txdat.txdat_req_ready = (state_q == StRun) && !full;
  assign push                  = txdat.txdat_req_valid && txdat.txdat_req_ready;
  assign any_send              = data_send || ret_send;

  always_comb begin
    state_d   = state_q;
    data_send = 1'b0;
    ret_send  = 1'b0;
    unique case (state_q)
      StStop: begin
        if (run_state) state_d = StRun;
      end
      StRun: begin
        data_send = !empty && crd_avail;
        if (!run_state) state_d = StDrain;
      end
      StDrain: begin
        data_send = !empty && crd_avail;
        if (empty && !data_send) state_d = StReturn;
      end
      StReturn: begin
        ret_send = crd_avail;
        if (!crd_avail) state_d = StStop;
      end
      default: state_d = StStop;
    endcase
  end

  // A credit grant and a send in the same cycle cancel out; grants beyond the max are lost.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (txdat.txdat_lcrdv && !any_send) begin
      if (cnt_q == CrdMax) ovf_d = 1'b1;
      else                 cnt_d = cnt_q + CntOne;
    end else if (!txdat.txdat_lcrdv && any_send) begin
      cnt_d = cnt_q - CntOne;
    end
  end

  always_comb begin
    flit_d = data_send ? mem_q[rd_ptr_q[PtrW-1:0]] : '0;
    pend_d = (state_q != StStop) && (!empty || push || (state_q == StReturn));
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PtrW-1:0]] <= txdat.txdat_req_flit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StStop;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      flitv_q  <= 1'b0;
      pend_q   <= 1'b0;
      flit_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      flitv_q <= any_send;
      pend_q  <= pend_d;
      flit_q  <= flit_d;
      if (push)      wr_ptr_q <= wr_ptr_q + PtrOne;
      if (data_send) rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  assign txdat.txdatflitv    = flitv_q;
  assign txdat.txdatflitpend = pend_q;
  assign txdat.txdatflit     = flit_q;
  assign txdat_crd_ret_done  = (state_q == StStop);
  assign txdat_crd_ovf_err   = ovf_q;

endmodule

// File: tb/tb_snf_txdat.sv
// Bench for snf_txdat: directed vector table, corner-case sequences and random traffic
// checked every cycle against a queue-based reference model.
module tb_snf_txdat;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CMAX  = 15;
  localparam int unsigned FW    = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run_state = 1'b0;
  logic ret_done, ovf_err;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  snf_txdat_if #(.FLIT_WIDTH(FW)) bus ();

  snf_txdat #(
    .TXDAT_FIFO_DEPTH(DEPTH),
    .TXDAT_CRD_MAX   (CMAX),
    .FLIT_WIDTH      (FW)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .run_state         (run_state),
    .txdat             (bus),
    .txdat_crd_ret_done(ret_done),
    .txdat_crd_ovf_err (ovf_err)
  );

  // Reference model: channel mode 0=stop 1=run 2=drain 3=return, FIFO as a queue.
  logic [FW-1:0] m_q[$];
  int            m_cnt, m_st;
  bit            m_flitv, m_pend, m_ovf;
  logic [FW-1:0] m_flit;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_cnt = 0; m_st = 0; m_flitv = 0; m_pend = 0; m_ovf = 0; m_flit = '0;
    end else begin : upd
      bit push, dsend, rsend;
      int nc;
      push    = bus.txdat_req_valid && (m_st == 1) && (m_q.size() < DEPTH);
      dsend   = (m_st == 1 || m_st == 2) && (m_q.size() != 0) && (m_cnt > 0);
      rsend   = (m_st == 3) && (m_cnt > 0);
      m_pend  = (m_st != 0) && (m_q.size() != 0 || push || m_st == 3);
      m_flitv = dsend || rsend;
      m_flit  = dsend ? m_q[0] : '0;
      nc = m_cnt + (bus.txdat_lcrdv ? 1 : 0) - ((dsend || rsend) ? 1 : 0);
      if (nc > int'(CMAX)) begin nc = CMAX; m_ovf = 1; end
      case (m_st)
        0: if (run_state) m_st = 1;
        1: if (!run_state) m_st = 2;
        2: if (m_q.size() == 0) m_st = 3;
        3: if (m_cnt == 0) m_st = 0;
        default: m_st = 0;
      endcase
      if (dsend) void'(m_q.pop_front());
      if (push) m_q.push_back(bus.txdat_req_flit);
      m_cnt = nc;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("m_flitv", bus.txdatflitv, m_flitv);
    chk("m_flit", bus.txdatflit, m_flit);
    chk("m_pend", bus.txdatflitpend, m_pend);
    chk("m_ready", bus.txdat_req_ready, (m_st == 1) && (m_q.size() < DEPTH));
    chk("m_ret_done", ret_done, m_st == 0);
    chk("m_ovf", ovf_err, m_ovf);
  endtask

  // Checks the current cycle's outputs, then drives inputs for the next rising edge.
  task automatic tick(input bit run, input bit v, input logic [FW-1:0] f, input bit cr);
    @(negedge clk);
    check_model();
    run_state           = run;
    bus.txdat_req_valid = v;
    bus.txdat_req_flit  = f;
    bus.txdat_lcrdv     = cr;
  endtask

  logic [FW-1:0] seen[$];

  task automatic tick_obs(input bit run, input bit v, input logic [FW-1:0] f, input bit cr);
    tick(run, v, f, cr);
    if (bus.txdatflitv) seen.push_back(bus.txdatflit);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    run_state = 1'b0;
    bus.txdat_req_valid = 1'b0;
    bus.txdat_req_flit  = '0;
    bus.txdat_lcrdv     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Deasserts run_state until the channel stops; counts data and return flits seen.
  task automatic drain(output int ndata, output int nret);
    ndata = 0; nret = 0;
    for (int i = 0; i < 60 && !(ret_done && i > 0); i++) begin
      tick_obs(1'b0, 1'b0, '0, 1'b0);
    end
    chk("drain_done", ret_done, 1'b1);
    foreach (seen[i]) if (seen[i] == '0) nret++; else ndata++;
  endtask

  typedef struct {
    bit run, v, cr;
    logic [FW-1:0] f;
    bit e_flitv, e_pend, e_ready, e_done;
    logic [FW-1:0] e_flit;
  } vec_t;

  vec_t tbl[14];
  localparam logic [FW-1:0] FA = 32'hA5A5_0001;

  initial begin
    int nd, nr;
    bit found, run;
    bus.txdat_req_valid = 1'b0;
    bus.txdat_req_flit  = '0;
    bus.txdat_lcrdv     = 1'b0;

    tbl[0]  = '{0, 0, 0, '0, 0, 0, 0, 1, '0};
    tbl[1]  = '{1, 0, 1, '0, 0, 0, 0, 1, '0};
    tbl[2]  = '{1, 0, 1, '0, 0, 0, 1, 0, '0};
    tbl[3]  = '{1, 0, 1, '0, 0, 0, 1, 0, '0};
    tbl[4]  = '{1, 1, 0, FA, 0, 0, 1, 0, '0};
    tbl[5]  = '{1, 0, 0, '0, 0, 1, 1, 0, '0};
    tbl[6]  = '{1, 0, 0, '0, 1, 1, 1, 0, FA};
    tbl[7]  = '{0, 0, 0, '0, 0, 0, 1, 0, '0};
    tbl[8]  = '{0, 0, 0, '0, 0, 0, 0, 0, '0};
    tbl[9]  = '{0, 0, 0, '0, 0, 0, 0, 0, '0};
    tbl[10] = '{0, 0, 0, '0, 1, 1, 0, 0, '0};
    tbl[11] = '{0, 0, 0, '0, 1, 1, 0, 0, '0};
    tbl[12] = '{0, 0, 0, '0, 0, 1, 0, 1, '0};
    tbl[13] = '{0, 0, 0, '0, 0, 0, 0, 1, '0};

    // Reset values while held in reset
    @(negedge clk);
    chk("rst_flitv", bus.txdatflitv, 1'b0);
    chk("rst_pend", bus.txdatflitpend, 1'b0);
    chk("rst_flit", bus.txdatflit, '0);
    chk("rst_ready", bus.txdat_req_ready, 1'b0);
    chk("rst_done", ret_done, 1'b1);
    chk("rst_ovf", ovf_err, 1'b0);

    // Table: 3 credits, one flit, then deactivate and return the 2 leftover credits
    do_reset();
    for (int i = 0; i < 14; i++) begin
      tick(tbl[i].run, tbl[i].v, tbl[i].f, tbl[i].cr);
      chk($sformatf("tbl%0d_flitv", i), bus.txdatflitv, tbl[i].e_flitv);
      chk($sformatf("tbl%0d_pend", i), bus.txdatflitpend, tbl[i].e_pend);
      chk($sformatf("tbl%0d_ready", i), bus.txdat_req_ready, tbl[i].e_ready);
      chk($sformatf("tbl%0d_done", i), ret_done, tbl[i].e_done);
      chk($sformatf("tbl%0d_flit", i), bus.txdatflit, tbl[i].e_flit);
    end

    // Fill FIFO with no credits, release two, then drain with six credits
    do_reset();
    tick(1, 0, '0, 0);
    for (int i = 1; i <= 4; i++) tick(1, 1, FW'(32'h100 + i), 0);
    tick(1, 0, '0, 0);
    chk("full_ready", bus.txdat_req_ready, 1'b0);
    chk("full_pend", bus.txdatflitpend, 1'b1);
    chk("full_flitv", bus.txdatflitv, 1'b0);
    seen.delete();
    tick_obs(1, 0, '0, 1);
    tick_obs(1, 0, '0, 1);
    repeat (6) tick_obs(1, 0, '0, 0);
    chk("two_crd_count", seen.size(), 2);
    if (seen.size() == 2) begin
      chk("two_crd_f0", seen[0], 32'h101);
      chk("two_crd_f1", seen[1], 32'h102);
    end
    seen.delete();
    for (int i = 0; i < 6; i++) tick_obs(0, 0, '0, 1);
    drain(nd, nr);
    chk("drain_data", nd, 2);
    chk("drain_ret", nr, 4);
    if (seen.size() == 6) begin
      chk("drain_f0", seen[0], 32'h103);
      chk("drain_f1", seen[1], 32'h104);
    end

    // Credit grant coinciding with a send at cnt=5 leaves cnt=5
    do_reset();
    repeat (5) tick(1, 0, '0, 1);
    tick(1, 1, 32'hB0B0, 0);
    tick(1, 0, '0, 1);
    seen.delete();
    drain(nd, nr);
    chk("same_cyc_data", nd, 1);
    chk("same_cyc_ret", nr, 5);

    // Overflow: 16 grants from zero in STOP
    do_reset();
    for (int i = 0; i < 16; i++) begin
      tick(0, 0, '0, 1);
      if (i == 15) chk("ovf_at_max", ovf_err, 1'b0);
    end
    tick(0, 0, '0, 0);
    chk("ovf_set", ovf_err, 1'b1);
    tick(1, 0, '0, 0);
    tick(1, 0, '0, 0);
    seen.delete();
    drain(nd, nr);
    chk("ovf_ret", nr, 15);
    chk("ovf_sticky", ovf_err, 1'b1);

    // Reset while a flit is on the link during DRAIN
    do_reset();
    tick(1, 0, '0, 0);
    for (int i = 1; i <= 3; i++) tick(1, 1, FW'(32'h200 + i), 0);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(0, 0, '0, 1);
      found = bus.txdatflitv && !ret_done && !bus.txdat_req_ready;
    end
    chk("drain_flitv_seen", found, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_flitv", bus.txdatflitv, 1'b0);
    chk("midrst_pend", bus.txdatflitpend, 1'b0);
    chk("midrst_ready", bus.txdat_req_ready, 1'b0);
    chk("midrst_done", ret_done, 1'b1);
    run_state = 1'b0;
    bus.txdat_lcrdv = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(1, 0, '0, 0);
    chk("postrst_stop", ret_done, 1'b1);
    tick(1, 0, '0, 0);
    seen.delete();
    drain(nd, nr);
    chk("postrst_noret", seen.size(), 0);

    // Random traffic against the model
    do_reset();
    run = 0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 19) == 0) run = !run;
      tick(run, 1'($urandom_range(0, 1)), FW'($urandom),
           (i < 1500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0));
    end
    tick(0, 0, '0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
